// File: rtl/student_fir_pkg.sv
// Shared types and helpers for the FIR scheduler: FSM state encoding and
// the output-width rule for summing several unit results.
package student_fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    SUM,
    OUT
  } fir_sched_state_t;

  // Width needed to sum n unsigned w-bit values without overflow.
  function automatic int fir_out_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/student_fir_scheduler.sv
// Feeds one sample to NUM_FIR parallel FIR units, waits for their done pulses
// (with timeout), sums the partial results serially and offers the total on valid/ready.
module student_fir_scheduler
  import student_fir_pkg::*;
#(
  parameter int NUM_FIR           = 4,
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int TIMEOUT_CYCLES    = 2048,
  localparam int OUT_WIDTH        = fir_out_width(NUM_FIR, DATA_SIZE_FIR_OUT)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [DATA_SIZE-1:0]                 sample_i,
  input  logic                                 sample_valid_i,
  output logic                                 sample_ready_o,
  input  logic [NUM_FIR-1:0]                   unit_en_i,
  output logic                                 fir_strobe_o,
  output logic [DATA_SIZE-1:0]                 fir_sample_o,
  input  logic [NUM_FIR-1:0]                   fir_done_i,
  input  logic [NUM_FIR*DATA_SIZE_FIR_OUT-1:0] fir_y_i,
  output logic [OUT_WIDTH-1:0]                 y_o,
  output logic                                 y_valid_o,
  input  logic                                 y_ready_i,
  output logic                                 busy_o,
  output logic                                 timeout_err_o,
  input  logic                                 clear_err_i
);

  localparam int W     = DATA_SIZE_FIR_OUT;
  localparam int IDX_W = (NUM_FIR > 1) ? $clog2(NUM_FIR) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIR - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  fir_sched_state_t       state_reg;
  logic [NUM_FIR-1:0]     en_reg;
  logic [NUM_FIR-1:0]     done_reg;
  logic [W-1:0]           y_reg [NUM_FIR];
  logic [W-1:0]           fir_y_unit [NUM_FIR];
  logic [TMO_W-1:0]       tmo_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [OUT_WIDTH-1:0]   acc_reg;
  logic [OUT_WIDTH-1:0]   sum_term;
  logic                   all_done;

  for (genvar gi = 0; gi < NUM_FIR; gi++) begin : g_unpack
    assign fir_y_unit[gi] = fir_y_i[gi*W +: W];
  end

  // Pulses arriving this cycle count towards completion, so the exit is not delayed.
  assign all_done = &(done_reg | fir_done_i | ~en_reg);

  always_comb begin
    sum_term = '0;
    if (en_reg[idx_reg] && done_reg[idx_reg])
      sum_term = OUT_WIDTH'(y_reg[idx_reg]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      en_reg         <= '0;
      done_reg       <= '0;
      tmo_reg        <= '0;
      idx_reg        <= '0;
      acc_reg        <= '0;
      sample_ready_o <= 1'b0;
      fir_strobe_o   <= 1'b0;
      fir_sample_o   <= '0;
      y_o            <= '0;
      y_valid_o      <= 1'b0;
      busy_o         <= 1'b0;
      timeout_err_o  <= 1'b0;
      for (int k = 0; k < NUM_FIR; k++) y_reg[k] <= '0;
    end else begin
      // A timeout set later in this block overrides the clear.
      if (clear_err_i) timeout_err_o <= 1'b0;

      case (state_reg)
        IDLE: begin
          sample_ready_o <= 1'b1;
          if (sample_valid_i && sample_ready_o) begin
            fir_sample_o   <= sample_i;
            en_reg         <= unit_en_i;
            done_reg       <= '0;
            tmo_reg        <= '0;
            fir_strobe_o   <= 1'b1;
            sample_ready_o <= 1'b0;
            busy_o         <= 1'b1;
            state_reg      <= STROBE;
          end
        end

        STROBE: begin
          fir_strobe_o <= 1'b0;
          state_reg    <= WAIT;
        end

        WAIT: begin
          done_reg <= done_reg | fir_done_i;
          for (int k = 0; k < NUM_FIR; k++)
            if (fir_done_i[k] && !done_reg[k]) y_reg[k] <= fir_y_unit[k];
          tmo_reg <= tmo_reg + 1'b1;
          if (all_done || tmo_reg == TMO_LAST) begin
            if (!all_done) timeout_err_o <= 1'b1;
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= SUM;
          end
        end

        SUM: begin
          acc_reg <= acc_reg + sum_term;
          idx_reg <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            y_o       <= acc_reg + sum_term;
            y_valid_o <= 1'b1;
            state_reg <= OUT;
          end
        end

        OUT: begin
          if (y_ready_i) begin
            y_valid_o      <= 1'b0;
            busy_o         <= 1'b0;
            sample_ready_o <= 1'b1;
            state_reg      <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_student_fir_scheduler.sv
// Directed plus randomized transactions against a per-sample reference model
// of which unit results land in the sum, when the total appears and whether it times out.
module tb_student_fir_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = 32;
  localparam int T  = 16;
  localparam int OW = 34;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [DW-1:0]     sample_i = '0;
  logic              sample_valid_i = 1'b0;
  logic              sample_ready_o;
  logic [N-1:0]      unit_en_i = '0;
  logic              fir_strobe_o;
  logic [DW-1:0]     fir_sample_o;
  logic [N-1:0]      fir_done_i = '0;
  logic [N*W-1:0]    fir_y_i = '0;
  logic [OW-1:0]     y_o;
  logic              y_valid_o;
  logic              y_ready_i = 1'b0;
  logic              busy_o;
  logic              timeout_err_o;
  logic              clear_err_i = 1'b0;

  student_fir_scheduler #(
    .NUM_FIR(N), .DATA_SIZE(DW), .DATA_SIZE_FIR_OUT(W), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sample_i(sample_i), .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .unit_en_i(unit_en_i), .fir_strobe_o(fir_strobe_o), .fir_sample_o(fir_sample_o),
    .fir_done_i(fir_done_i), .fir_y_i(fir_y_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i),
    .busy_o(busy_o), .timeout_err_o(timeout_err_o), .clear_err_i(clear_err_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Pulse schedule per unit, in cycles after the strobe cycle (0 = no pulse).
  int           p1_cyc [N];
  int           p2_cyc [N];
  logic [W-1:0] p1_y   [N];
  logic [W-1:0] p2_y   [N];
  logic [N-1:0] stray;
  logic         err_model = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {sample_ready_o, fir_strobe_o, fir_sample_o, y_o, y_valid_o, busy_o, timeout_err_o}, 64'd0);
  endtask

  task automatic clear_sched();
    for (int k = 0; k < N; k++) begin
      p1_cyc[k] = 0; p2_cyc[k] = 0; p1_y[k] = '0; p2_y[k] = '0;
    end
    stray = '0;
  endtask

  task automatic run_tx(input logic [DW-1:0] smp, input logic [N-1:0] en, input int bp, input string name);
    logic [OW-1:0] exp_y;
    int            d;
    logic          miss;
    int            strobes;
    exp_y = '0; d = 1; miss = 1'b0; strobes = 0;
    // Reference: each enabled unit contributes its first in-window result;
    // any enabled unit missing from the window forces a full-length timeout.
    for (int k = 0; k < N; k++) begin
      if (en[k]) begin
        if (p1_cyc[k] >= 1 && p1_cyc[k] <= T) begin
          exp_y += OW'(p1_y[k]);
          if (p1_cyc[k] > d) d = p1_cyc[k];
        end else begin
          miss = 1'b1;
        end
      end
    end
    if (miss) d = T;
    err_model = err_model | miss;

    check({name, " ready_before"}, sample_ready_o, 1);
    sample_i = smp; unit_en_i = en; sample_valid_i = 1'b1;
    @(posedge clk_i); #1;
    sample_valid_i = 1'b0; sample_i = DW'($urandom); unit_en_i = N'($urandom);

    for (int c = 0; c <= d + 5; c++) begin
      fir_done_i = '0;
      fir_y_i = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < N; k++) begin
        if (c == 0 && stray[k]) begin
          fir_done_i[k] = 1'b1;
        end else if (c != 0 && c == p1_cyc[k]) begin
          fir_done_i[k] = 1'b1; fir_y_i[k*W +: W] = p1_y[k];
        end else if (c != 0 && c == p2_cyc[k]) begin
          fir_done_i[k] = 1'b1; fir_y_i[k*W +: W] = p2_y[k];
        end
      end
      strobes += int'(fir_strobe_o);
      if (c == 0) begin
        check({name, " fir_sample"}, fir_sample_o, smp);
        check({name, " busy_inflight"}, busy_o, 1);
        check({name, " ready_inflight"}, sample_ready_o, 0);
      end
      if (c == d + 4) check({name, " valid_early"}, y_valid_o, 0);
      if (c == d + 5) begin
        check({name, " valid"}, y_valid_o, 1);
        check({name, " y"}, y_o, exp_y);
        check({name, " timeout_err"}, timeout_err_o, err_model);
      end
      if (c < d + 5) begin
        @(posedge clk_i); #1;
      end
    end
    fir_done_i = '0;
    check({name, " strobe_count"}, strobes, 1);

    repeat (bp) begin
      @(posedge clk_i); #1;
      check({name, " bp_valid"}, y_valid_o, 1);
      check({name, " bp_y"}, y_o, exp_y);
      check({name, " bp_ready"}, sample_ready_o, 0);
    end
    y_ready_i = 1'b1;
    @(posedge clk_i); #1;
    y_ready_i = 1'b0;
    check({name, " valid_after_hs"}, y_valid_o, 0);
    check({name, " ready_after_hs"}, sample_ready_o, 1);
    check({name, " busy_after_hs"}, busy_o, 0);
    $display("tx %s: sample=0x%h en=%b y_exp=0x%h err_exp=%0d", name, smp, en, exp_y, err_model);
  endtask

  initial begin
    logic seen_valid;
    clear_sched();

    // Asynchronous reset asserted mid-cycle.
    #1 rst_i = 1'b1;
    #2 check_reset_outputs("reset_async");
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("ready_after_reset", sample_ready_o, 1);
    check("busy_after_reset", busy_o, 0);

    // Basic
    clear_sched();
    p1_cyc = '{5, 7, 9, 12};
    p1_y   = '{32'd10, 32'd20, 32'd30, 32'd40};
    run_tx(16'h1234, 4'hF, 0, "basic");

    // Backpressure
    clear_sched();
    p1_cyc = '{3, 1, 6, 4};
    p1_y   = '{32'd111, 32'd222, 32'd333, 32'd444};
    run_tx(16'hBEEF, 4'hF, 3, "backpressure");

    // Masked units pulse with large values that must not be summed.
    clear_sched();
    p1_cyc = '{3, 4, 6, 2};
    p1_y   = '{32'd7, 32'd1000, 32'd9, 32'd1000};
    run_tx(16'h0055, 4'b0101, 0, "mask");

    // Timeout: unit 3 never answers.
    clear_sched();
    p1_cyc = '{2, 3, 4, 0};
    p1_y   = '{32'd1, 32'd2, 32'd3, 32'd0};
    run_tx(16'h0777, 4'hF, 0, "timeout");

    // Sticky error persists across a clean sample, with repeated and stray pulses.
    clear_sched();
    p1_cyc = '{1, 2, 3, 4};
    p2_cyc = '{5, 0, 6, 0};
    p1_y   = '{32'd5, 32'd6, 32'd7, 32'd8};
    p2_y   = '{32'd900, 32'd0, 32'd900, 32'd0};
    stray  = 4'b1010;
    run_tx(16'h0ABC, 4'hF, 1, "sticky");

    clear_err_i = 1'b1;
    @(posedge clk_i); #1;
    clear_err_i = 1'b0;
    err_model = 1'b0;
    check("clear_err", timeout_err_o, 0);

    // No units enabled: strobes anyway, empty sum.
    clear_sched();
    p1_cyc = '{2, 3, 4, 5};
    p1_y   = '{32'd1, 32'd1, 32'd1, 32'd1};
    run_tx(16'h0F0F, 4'h0, 0, "none_enabled");

    // Overflow: maximum unit results.
    clear_sched();
    p1_cyc = '{4, 8, 2, 16};
    p1_y   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_tx(16'hFFFF, 4'hF, 0, "overflow");

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      clear_sched();
      for (int k = 0; k < N; k++) begin
        int mode;
        mode = int'($urandom_range(0, 9));
        p1_y[k] = (mode == 9) ? 32'hFFFF_FFFF : $urandom;
        p2_y[k] = $urandom;
        if (mode == 0)      p1_cyc[k] = 0;
        else if (mode == 1) p1_cyc[k] = T + int'($urandom_range(1, 3));
        else begin
          p1_cyc[k] = int'($urandom_range(1, T));
          if ($urandom_range(0, 2) == 0) p2_cyc[k] = p1_cyc[k] + int'($urandom_range(1, 5));
        end
        stray[k] = ($urandom_range(0, 3) == 0);
      end
      run_tx(DW'($urandom), N'($urandom), int'($urandom_range(0, 2)), $sformatf("rand%0d", t));
      if ($urandom_range(0, 3) == 0) begin
        clear_err_i = 1'b1;
        @(posedge clk_i); #1;
        clear_err_i = 1'b0;
        err_model = 1'b0;
        check($sformatf("rand%0d clear", t), timeout_err_o, 0);
      end
    end

    // Reset during WAIT aborts the sample: no result may appear.
    check("abort ready_before", sample_ready_o, 1);
    sample_i = 16'h4321; unit_en_i = 4'hF; sample_valid_i = 1'b1;
    @(posedge clk_i); #1;
    sample_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    #1 rst_i = 1'b1;
    #1 check_reset_outputs("abort_reset");
    @(posedge clk_i); #1 rst_i = 1'b0;
    err_model = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      fir_done_i = N'($urandom);
      fir_y_i = {4{32'hFFFF_FFFF}};
      @(posedge clk_i); #1;
      seen_valid = seen_valid | y_valid_o;
    end
    fir_done_i = '0;
    check("abort_no_valid", seen_valid, 0);
    check("abort_ready", sample_ready_o, 1);
    check("abort_err", timeout_err_o, 0);
    $display("tx abort: reset during WAIT, valid_seen=%0d", seen_valid);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound in case a transaction stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
